// File: rtl/booth4_datapath.sv
// rtl/booth4_datapath.sv - radix-4 Booth multiplier datapath driven by external control strobes c0..c6
// Optional BOOTH_CTRL_CHECK_EN adds a sticky ctrl_err output flagging illegal strobe combinations.
module booth4_datapath #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 3
) (
  input  logic                 clk,
  input  logic                 rst_b,
  input  logic [WIDTH-1:0]     inbus,
  input  logic                 c0,
  input  logic                 c1,
  input  logic                 c2,
  input  logic                 c3,
  input  logic                 c4,
  input  logic                 c5,
  input  logic                 c6,
  output logic                 q1,
  output logic                 q0,
  output logic                 q,
  output logic                 is_count_3,
  output logic [2*WIDTH-1:0]   outbus,
  output logic                 out_valid
`ifdef BOOTH_CTRL_CHECK_EN
  ,
  output logic                 ctrl_err
`endif
);

  logic signed [WIDTH-1:0] m;
  logic signed [WIDTH+1:0] a;
  logic [WIDTH-1:0]        qr;
  logic                    qm1;
  logic [CNT_W-1:0]        cnt;
  logic signed [WIDTH+1:0] m_ext;
  logic signed [WIDTH+1:0] operand;

  // Two guard bits on A keep +/-2M from overflowing the accumulator.
  assign m_ext   = {{2{m[WIDTH-1]}}, m};
  assign operand = c3 ? {m_ext[WIDTH:0], 1'b0} : m_ext;

  assign q1         = qr[1];
  assign q0         = qr[0];
  assign q          = qm1;
  assign is_count_3 = (cnt == CNT_W'(WIDTH/2 - 1));

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      m   <= '0;
      a   <= '0;
      qr  <= '0;
      qm1 <= 1'b0;
      cnt <= '0;
    end else if (c0) begin
      m   <= inbus;
      a   <= '0;
      cnt <= '0;
      qm1 <= 1'b0;
    end else if (c1) begin
      qr  <= inbus;
      qm1 <= 1'b0;
    end else if (c2) begin
      a <= c4 ? (a - operand) : (a + operand);
    end else if (c5) begin
      qm1 <= qr[1];
      qr  <= {a[1:0], qr[WIDTH-1:2]};
      a   <= a >>> 2;
      cnt <= cnt + 1'b1;
    end
  end

  // Product capture is independent of the update chain and sees pre-edge A/Q.
  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      outbus    <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= c6;
      if (c6) outbus <= {a[WIDTH-1:0], qr};
    end
  end

`ifdef BOOTH_CTRL_CHECK_EN
  logic [2:0] hot;
  assign hot = 3'(c0) + 3'(c1) + 3'(c2) + 3'(c5) + 3'(c6);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      ctrl_err <= 1'b0;
    end else if ((hot > 3'd1) || ((c3 || c4) && !c2)) begin
      ctrl_err <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_booth4_datapath.sv
// tb/tb_booth4_datapath.sv - randomized self-checking bench for booth4_datapath against signed multiply
// Builds with or without BOOTH_CTRL_CHECK_EN.
module tb_booth4_datapath;
  localparam int W = 8;
  localparam int CW = 3;

  localparam logic [6:0] C0 = 7'b0000001;
  localparam logic [6:0] C1 = 7'b0000010;
  localparam logic [6:0] C2 = 7'b0000100;
  localparam logic [6:0] C3 = 7'b0001000;
  localparam logic [6:0] C4 = 7'b0010000;
  localparam logic [6:0] C5 = 7'b0100000;
  localparam logic [6:0] C6 = 7'b1000000;

  logic           clk = 1'b0;
  logic           rst_b = 1'b0;
  logic [W-1:0]   inbus = '0;
  logic           c0 = 0, c1 = 0, c2 = 0, c3 = 0, c4 = 0, c5 = 0, c6 = 0;
  logic           q1, q0, q, is_count_3, out_valid;
  logic [2*W-1:0] outbus;
`ifdef BOOTH_CTRL_CHECK_EN
  logic           ctrl_err;
`endif

  int total = 0;
  int bad = 0;

  booth4_datapath #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_b(rst_b), .inbus(inbus),
    .c0(c0), .c1(c1), .c2(c2), .c3(c3), .c4(c4), .c5(c5), .c6(c6),
    .q1(q1), .q0(q0), .q(q), .is_count_3(is_count_3),
    .outbus(outbus), .out_valid(out_valid)
`ifdef BOOTH_CTRL_CHECK_EN
    , .ctrl_err(ctrl_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [6:0] s, input logic [W-1:0] d);
    {c6, c5, c4, c3, c2, c1, c0} = s;
    inbus = d;
    @(posedge clk);
    #1;
    {c6, c5, c4, c3, c2, c1, c0} = '0;
  endtask

  // Booth triple for digit i: {y[2i+1], y[2i], y[2i-1]} with y[-1] = 0.
  function automatic logic [2:0] triple(input logic [W-1:0] y, input int i);
    logic lo;
    lo = (i == 0) ? 1'b0 : y[2*i-1];
    return {y[2*i+1], y[2*i], lo};
  endfunction

  function automatic int digit(input logic [2:0] t);
    return -2 * int'(t[2]) + int'(t[1]) + int'(t[0]);
  endfunction

  task automatic run_mul(input logic [W-1:0] mv, input logic [W-1:0] qv);
    int d;
    int p;
    logic [6:0] s;
    logic [2*W-1:0] expv;
    p = int'($signed(mv)) * int'($signed(qv));
    expv = p[2*W-1:0];
    cyc(C0, mv);
    cyc(C1, qv);
    check("recode0", {29'd0, q1, q0, q}, {29'd0, triple(qv, 0)});
    for (int i = 0; i < W/2; i++) begin
      d = digit(triple(qv, i));
      if (d != 0) begin
        s = C2;
        if (d == 2 || d == -2) s = s | C3;
        if (d < 0) s = s | C4;
        cyc(s, '0);
      end
      cyc(C5, '0);
      check("is_count_3", {31'd0, is_count_3}, {31'd0, (i + 1) == (W/2 - 1)});
      if (i + 1 < W/2)
        check("recode", {29'd0, q1, q0, q}, {29'd0, triple(qv, i + 1)});
    end
    cyc(C6, '0);
    check("out_valid_hi", {31'd0, out_valid}, 32'd1);
    check("product", {16'd0, outbus}, {16'd0, expv});
    cyc('0, '0);
    check("out_valid_lo", {31'd0, out_valid}, 32'd0);
    check("product_hold", {16'd0, outbus}, {16'd0, expv});
  endtask

  initial begin
    #1;
    check("rst_outbus", {16'd0, outbus}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_qbits", {29'd0, q1, q0, q}, 32'd0);
    check("rst_cnt3", {31'd0, is_count_3}, 32'd0);
`ifdef BOOTH_CTRL_CHECK_EN
    check("rst_ctrl_err", {31'd0, ctrl_err}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;

    run_mul(8'h07, 8'hFD);
    check("7xm3", {16'd0, outbus}, 32'h0000FFEB);
    run_mul(8'h80, 8'h80);
    check("m128sq", {16'd0, outbus}, 32'h00004000);
    run_mul(8'h7F, 8'h7F);
    check("127sq", {16'd0, outbus}, 32'h00003F01);
    run_mul(8'h80, 8'h7F);
    check("m128x127", {16'd0, outbus}, 32'h0000C080);

    for (int k = 0; k < 40; k++)
      run_mul(W'($urandom), W'($urandom));

    // Recode bit visibility and a single shift with A = 0.
    cyc(C0, 8'h00);
    cyc(C1, 8'h03);
    check("q03_bits", {29'd0, q1, q0, q}, 32'b110);
    cyc(C5, '0);
    check("q03_shift", {29'd0, q1, q0, q}, 32'b001);

    // Counter reaches WIDTH/2-1 only after the third shift.
    cyc(C0, 8'h00);
    for (int i = 1; i <= 4; i++) begin
      cyc(C5, '0);
      check("cnt_seq", {31'd0, is_count_3}, {31'd0, i == 3});
    end

`ifdef BOOTH_CTRL_CHECK_EN
    check("ctrl_err_clean", {31'd0, ctrl_err}, 32'd0);
`endif

    // Asynchronous reset in the middle of an iteration.
    cyc(C0, 8'h35);
    cyc(C1, 8'h5A);
    cyc(C2, '0);
    cyc(C5, '0);
    cyc(C2 | C3 | C4, '0);
    cyc(C5, '0);
    #2;
    rst_b = 1'b0;
    #1;
    check("mid_rst_outbus", {16'd0, outbus}, 32'd0);
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_qbits", {29'd0, q1, q0, q}, 32'd0);
    check("mid_rst_cnt3", {31'd0, is_count_3}, 32'd0);
    @(posedge clk); #1;
    rst_b = 1'b1;
    @(posedge clk); #1;
    run_mul(8'd5, 8'd6);
    check("5x6", {16'd0, outbus}, 32'h0000001E);

    // Add wins over shift when c2 and c5 collide.
    cyc(C0, 8'h03);
    cyc(C1, 8'h55);
    cyc(C2 | C5, '0);
    check("prio_qbits", {29'd0, q1, q0, q}, 32'b010);
    cyc(C6, '0);
    check("prio_outbus", {16'd0, outbus}, 32'h00000355);
`ifdef BOOTH_CTRL_CHECK_EN
    check("ctrl_err_set", {31'd0, ctrl_err}, 32'd1);
    cyc('0, '0);
    cyc('0, '0);
    check("ctrl_err_sticky", {31'd0, ctrl_err}, 32'd1);
    rst_b = 1'b0;
    #1;
    check("ctrl_err_rst", {31'd0, ctrl_err}, 32'd0);
    rst_b = 1'b1;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
